// File: rtl/dbg_step_ctrl.sv
// dbg_step_ctrl: debug execution controller for the sbmips core.
// Generates the CPU clock enable in HALT/RUN/STEP/BURST modes from a
// debounced step button, counts enabled cycles and pages any probe
// channel (or the cycle counter) onto a narrow LED bank.
// Optional feature: define DBG_SNAPSHOT_EN to display a post-execution
// snapshot of the probes instead of the live probe bus.
module dbg_step_ctrl #(
  parameter int unsigned DBNC_CYCLES = 16,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned CH          = 8,
  parameter int unsigned PROBE_W     = 32,
  parameter int unsigned LED_W       = 12,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    step_btn,
  input  logic [7:0]              led_sel,
  input  logic [CH*PROBE_W-1:0]   probe,
  output logic                    cpu_ce,
  output logic                    busy,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [LED_W-1:0]        led
);

  localparam int unsigned DC_W   = (DBNC_CYCLES > 2) ? $clog2(DBNC_CYCLES) : 1;
  localparam int unsigned BL_W   = 8;
  localparam int unsigned WIDE_W = PROBE_W + LED_W;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_BURST_RUN
  } state_t;

  // Button path
  logic            r_sync1;
  logic            r_sync2;
  logic [DC_W-1:0] r_dcnt;
  logic            r_deb;
  logic            r_deb_q;
  logic            w_press;

  // FSM and outputs
  state_t          r_state;
  state_t          w_state_nx;
  logic [BL_W-1:0] r_rem;
  logic [BL_W-1:0] w_rem_nx;
  logic            r_cpu_ce;
  logic            w_ce_nx;
  logic            r_busy;
  logic            w_busy_nx;
  logic [CNT_W-1:0] r_cnt;

  // LED path
  logic [CH*PROBE_W-1:0] w_src;
  logic [PROBE_W-1:0]    w_sel;
  logic [31:0]           w_shamt;
  logic [LED_W-1:0]      w_led_nx;
  logic [LED_W-1:0]      r_led;

  // Synchronise the raw button and debounce it; a level change is accepted
  // only after DBNC_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dcnt  <= '0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
    end else begin
      r_sync1 <= step_btn;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      if (r_sync2 == r_deb) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DC_W'(DBNC_CYCLES - 1)) begin
        r_deb  <= ~r_deb;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DC_W'(1);
      end
    end
  end

  // One-cycle press pulse on the rising edge of the debounced level.
  assign w_press = r_deb & ~r_deb_q;

  // FSM state and registered enable/busy; r_rem counts enabled cycles
  // still owed in the burst, including the one currently on cpu_ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_cpu_ce <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_rem    <= w_rem_nx;
      r_cpu_ce <= w_ce_nx;
      r_busy   <= w_busy_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx = r_state;
    w_rem_nx   = r_rem;
    w_ce_nx    = 1'b0;
    w_busy_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        case (mode)
          MODE_RUN:  w_ce_nx = 1'b1;
          MODE_STEP: w_ce_nx = w_press;
          MODE_BURST: begin
            if (w_press) begin
              w_state_nx = S_BURST_RUN;
              w_rem_nx   = BL_W'(BURST_LEN);
              w_ce_nx    = 1'b1;
              w_busy_nx  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_BURST_RUN: begin
        case (mode)
          MODE_HALT: begin
            w_state_nx = S_IDLE;
            w_rem_nx   = '0;
          end
          MODE_RUN: begin
            w_state_nx = S_IDLE;
            w_rem_nx   = '0;
            w_ce_nx    = 1'b1;
          end
          default: begin
            // STEP or BURST: finish the burst, presses are dropped.
            if (r_rem <= BL_W'(1)) begin
              w_state_nx = S_IDLE;
              w_rem_nx   = '0;
            end else begin
              w_rem_nx   = r_rem - BL_W'(1);
              w_ce_nx    = 1'b1;
              w_busy_nx  = 1'b1;
            end
          end
        endcase
      end
      default: begin
        w_state_nx = S_IDLE;
        w_rem_nx   = '0;
      end
    endcase
  end

  // Executed-cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cpu_ce) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef DBG_SNAPSHOT_EN
  logic [CH*PROBE_W-1:0] r_snap;

  // Capture the probes after each executed cycle so the display is stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
    end else if (r_cpu_ce) begin
      r_snap <= probe;
    end
  end

  assign w_src = r_snap;
`else
  assign w_src = probe;
`endif

  // Select channel (probe, cycle counter, or zero) and extract the LED page.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < int'(CH); k++) begin
      if (led_sel[4:0] == 5'(k)) begin
        w_sel = w_src[k*PROBE_W +: PROBE_W];
      end
    end
    if (led_sel[4:0] == 5'(CH)) begin
      w_sel = PROBE_W'(r_cnt);
    end
    w_shamt  = 32'(led_sel[7:5]) * LED_W;
    w_led_nx = LED_W'(WIDE_W'(w_sel) >> w_shamt);
  end

  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_nx;
    end
  end

  assign cpu_ce    = r_cpu_ce;
  assign busy      = r_busy;
  assign cycle_cnt = r_cnt;
  assign led       = r_led;

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Testbench for dbg_step_ctrl: instance A (DBNC=4, CNT_W=32) for the main
// checks, instance B (DBNC=2, CNT_W=4) for counter wrap and mid-burst press.
module tb_dbg_step_ctrl;

  localparam int unsigned CH = 8;
  localparam int unsigned PW = 32;
  localparam int unsigned LW = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic              step_btn;
  logic [7:0]        led_sel;
  logic [CH*PW-1:0]  probe;

  logic              a_ce, a_busy, b_ce, b_busy;
  logic [31:0]       a_cnt;
  logic [3:0]        b_cnt;
  logic [LW-1:0]     a_led, b_led;

  int n_checks = 0;
  int n_fail   = 0;
  int nce_a, nce_b, nbusy_a, nmis_a;

  typedef struct {
    logic [7:0]  sel;
    logic [11:0] exp;
  } led_vec_t;
  led_vec_t vecs[12];

  always #5 clk = ~clk;

  dbg_step_ctrl #(.DBNC_CYCLES(4), .BURST_LEN(8), .CH(CH), .PROBE_W(PW),
                  .LED_W(LW), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn), .led_sel(led_sel),
    .probe(probe), .cpu_ce(a_ce), .busy(a_busy), .cycle_cnt(a_cnt), .led(a_led));

  dbg_step_ctrl #(.DBNC_CYCLES(2), .BURST_LEN(8), .CH(CH), .PROBE_W(PW),
                  .LED_W(LW), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn), .led_sel(led_sel),
    .probe(probe), .cpu_ce(b_ce), .busy(b_busy), .cycle_cnt(b_cnt), .led(b_led));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick and accumulate enable/busy statistics.
  task automatic tick_cnt();
    tick();
    if (a_ce === 1'b1) nce_a++;
    if (b_ce === 1'b1) nce_b++;
    if (a_busy === 1'b1) nbusy_a++;
    if (a_busy !== a_ce) nmis_a++;
  endtask

  task automatic clr_cnt();
    nce_a = 0; nce_b = 0; nbusy_a = 0; nmis_a = 0;
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst = 1'b1; mode = m; step_btn = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_ce(input int max, input string nm);
    int i;
    i = 0;
    while (a_ce !== 1'b1 && i < max) begin
      tick();
      i++;
    end
    if (a_ce !== 1'b1) chk(nm, 32'(a_ce), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h02, 12'hEEF};
    vecs[1]  = '{8'h22, 12'hADB};
    vecs[2]  = '{8'h42, 12'h0DE};
    vecs[3]  = '{8'h62, 12'h000};
    vecs[4]  = '{8'h09, 12'h000};
    vecs[5]  = '{8'h08, 12'h003};
    vecs[6]  = '{8'h28, 12'h000};
    vecs[7]  = '{8'h00, 12'h678};
    vecs[8]  = '{8'h20, 12'h345};
    vecs[9]  = '{8'h27, 12'hA5A};
    vecs[10] = '{8'h47, 12'h0A5};
    vecs[11] = '{8'hE2, 12'h000};

    // Reset with RUN selected and a nonzero LED source
    rst = 1'b1; mode = 2'b01; step_btn = 1'b0; led_sel = 8'h02;
    probe = '0;
    probe[2*PW +: PW] = 32'hDEADBEEF;
    tick(); tick();
    chk("rst_ce",   32'(a_ce),   32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_cnt",  a_cnt,       32'd0);
    chk("rst_led",  32'(a_led),  32'd0);
    rst = 1'b0;
    tick();
    chk("run_ce",   32'(a_ce), 32'd1);
    chk("run_cnt0", a_cnt,     32'd0);
    tick();
    chk("run_cnt1", a_cnt,     32'd1);
    tick();
    chk("run_cnt2", a_cnt,     32'd2);

    // Single step: pulse at E0+6 (k==7 since k==1 is E0)
    do_reset(2'b10);
    tick(); tick();
    chk("step_idle_ce", 32'(a_ce), 32'd0);
    step_btn = 1'b1;
    clr_cnt();
    for (int k = 1; k <= 9; k++) begin
      tick_cnt();
      if (k == 6) chk("step_pre",   32'(a_ce), 32'd0);
      if (k == 7) chk("step_pulse", 32'(a_ce), 32'd1);
      if (k == 8) chk("step_post",  32'(a_ce), 32'd0);
    end
    chk("step_npulse", 32'(nce_a), 32'd1);
    chk("step_cnt",    a_cnt,      32'd1);

    // 3-cycle glitch after a debounced release gives no press
    step_btn = 1'b0;
    repeat (12) tick();
    clr_cnt();
    step_btn = 1'b1;
    repeat (3) tick_cnt();
    step_btn = 1'b0;
    repeat (15) tick_cnt();
    chk("glitch_npulse", 32'(nce_a), 32'd0);
    chk("glitch_cnt",    a_cnt,      32'd1);

    // Burst of 8
    do_reset(2'b11);
    step_btn = 1'b1;
    clr_cnt();
    repeat (24) tick_cnt();
    chk("burst_nce",   32'(nce_a),   32'd8);
    chk("burst_nbusy", 32'(nbusy_a), 32'd8);
    chk("burst_align", 32'(nmis_a),  32'd0);
    chk("burst_cnt",   a_cnt,        32'd8);

    // Second debounced press mid-burst on B is discarded
    do_reset(2'b11);
    clr_cnt();
    step_btn = 1'b1; repeat (4) tick_cnt();
    step_btn = 1'b0; repeat (2) tick_cnt();
    step_btn = 1'b1; repeat (4) tick_cnt();
    step_btn = 1'b0; repeat (20) tick_cnt();
    chk("burst2_nce", 32'(nce_b), 32'd8);
    chk("burst2_cnt", 32'(b_cnt), 32'd8);

    // Burst aborted by HALT after 3 enabled cycles
    do_reset(2'b11);
    step_btn = 1'b1;
    wait_ce(20, "abort_start_timeout");
    tick(); tick();
    mode = 2'b00;
    tick();
    chk("halt_abort_ce",   32'(a_ce),   32'd0);
    chk("halt_abort_busy", 32'(a_busy), 32'd0);
    tick();
    chk("halt_abort_cnt",  a_cnt,       32'd3);

    // Burst aborted by RUN
    do_reset(2'b11);
    step_btn = 1'b1;
    wait_ce(20, "runab_start_timeout");
    tick();
    mode = 2'b01;
    tick();
    chk("run_abort_busy", 32'(a_busy), 32'd0);
    chk("run_abort_ce",   32'(a_ce),   32'd1);

    // Switching to STEP lets the burst complete
    do_reset(2'b11);
    step_btn = 1'b1;
    wait_ce(20, "stepc_start_timeout");
    tick();
    mode = 2'b10;
    repeat (15) tick();
    chk("step_complete_cnt", a_cnt, 32'd8);

    // Reset mid-burst
    do_reset(2'b11);
    step_btn = 1'b1;
    wait_ce(20, "rstb_start_timeout");
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_ce",   32'(a_ce),   32'd0);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    chk("midrst_cnt",  a_cnt,       32'd0);
    rst = 1'b0;

    // Counter wrap on B (CNT_W=4): 17 enabled cycles
    do_reset(2'b01);
    repeat (18) tick();
    chk("wrap_a_cnt", a_cnt,       32'd17);
    chk("wrap_b_cnt", 32'(b_cnt),  32'd1);

    // LED paging table
    probe = '0;
    probe[0*PW +: PW] = 32'h12345678;
    probe[2*PW +: PW] = 32'hDEADBEEF;
    probe[7*PW +: PW] = 32'hA5A5A5A5;
    do_reset(2'b01);
    repeat (3) tick();
    mode = 2'b00;
    tick(); tick();
    chk("led_setup_cnt", a_cnt, 32'd3);
    for (int i = 0; i < 12; i++) begin
      led_sel = vecs[i].sel;
      tick();
      chk($sformatf("led_vec%0d_sel%02h", i, vecs[i].sel), 32'(a_led), 32'(vecs[i].exp));
    end

    // Probe change without an executed cycle
    probe[2*PW +: PW] = 32'h00000123;
    led_sel = 8'h02;
    tick();
`ifdef DBG_SNAPSHOT_EN
    chk("led_snapshot_hold", 32'(a_led), 32'h0EEF);
`else
    chk("led_live_follow",   32'(a_led), 32'h0123);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
